day_counter: RTL and testbench

//  Day-of-month counter for the calendar chain. It sits upstream of the month counter.
//  - Advances on the day-rollover tick from the hour chain.
//  - Emits day_done, the single-cycle carry that serves as the month counter's enable.
//  - Days-in-month follows month/year from downstream, with optional Gregorian leap handling.
//  - Supports manual inc/dec setting and clamps the day when month/year change underneath it.

---
 rtl/day_counter.sv | 120 ++++++++++++
 tb/tb_day_counter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/day_counter.sv
// Day-of-month counter for the calendar chain: advances on the day tick, carries into the month
// counter, supports manual inc/dec setting and clamps when month/year shrink. Define LEAP_YEAR_EN for Gregorian February.
module day_counter #(
  parameter int YEAR_W      = 14,
  parameter int SYNC_INPUTS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_in,
  input  logic              set_enable,
  input  logic              set_mode,
  input  logic              inc,
  input  logic              dec,
  input  logic [3:0]        month,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        day,
  output logic [3:0]        day_tens,
  output logic [3:0]        day_units,
  output logic              day_done
);

  logic [4:0] r_day;
  logic       r_day_done;
  logic       r_inc_q;
  logic       r_dec_q;

  logic       w_inc_s;
  logic       w_dec_s;
  logic       w_inc_rise;
  logic       w_dec_rise;
  logic       w_leap;
  logic [4:0] w_dim;
  logic [4:0] w_day_nxt;
  logic       w_done_nxt;

  generate
    if (SYNC_INPUTS != 0) begin : g_sync
      logic [1:0] r_inc_sync;
      logic [1:0] r_dec_sync;

      // NOTE: the async reset also clears the synchroniser so a level held through reset registers as a fresh edge.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_inc_sync <= 2'b00;
          r_dec_sync <= 2'b00;
        end else begin
          r_inc_sync <= {r_inc_sync[0], inc};
          r_dec_sync <= {r_dec_sync[0], dec};
        end
      end

      assign w_inc_s = r_inc_sync[1];
      assign w_dec_s = r_dec_sync[1];
    end else begin : g_nosync
      assign w_inc_s = inc;
      assign w_dec_s = dec;
    end
  endgenerate

  assign w_inc_rise = w_inc_s & ~r_inc_q;
  assign w_dec_rise = w_dec_s & ~r_dec_q;

`ifdef LEAP_YEAR_EN
  assign w_leap = (((year % YEAR_W'(4)) == '0) && ((year % YEAR_W'(100)) != '0))
                || ((year % YEAR_W'(400)) == '0);
`else
  logic w_unused_year;
  assign w_unused_year = ^year;
  assign w_leap        = 1'b0;
`endif

  always_comb begin
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: w_dim = 5'd30;
      4'd2:                    w_dim = w_leap ? 5'd29 : 5'd28;
      default:                 w_dim = 5'd31;
    endcase
  end

  // Priority: set-mode single step > run tick > clamp (a simultaneous inc+dec is no step).
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_day_nxt  = r_day;
    w_done_nxt = 1'b0;
    if (set_enable && set_mode && (w_inc_rise ^ w_dec_rise)) begin
      if (w_inc_rise) w_day_nxt = (r_day >= w_dim) ? 5'd1 : r_day + 5'd1;
      else            w_day_nxt = (r_day <= 5'd1) ? w_dim : r_day - 5'd1;
    end else if (!set_enable && tick_in) begin
      if (r_day >= w_dim) begin
        w_day_nxt  = 5'd1;
        w_done_nxt = 1'b1;
      end else begin
        w_day_nxt = r_day + 5'd1;
      end
    end else if (r_day > w_dim) begin
      w_day_nxt = w_dim;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_day      <= 5'd1;
      r_day_done <= 1'b0;
      r_inc_q    <= 1'b0;
      r_dec_q    <= 1'b0;
    end else begin
      r_day      <= w_day_nxt;
      r_day_done <= w_done_nxt;
      r_inc_q    <= w_inc_s;
      r_dec_q    <= w_dec_s;
    end
  end

  assign day       = r_day;
  assign day_done  = r_day_done;
  assign day_tens  = 4'(r_day / 5'd10);
  assign day_units = 4'(r_day % 5'd10);

endmodule

// File: tb/tb_day_counter.sv
// Randomised + directed bench for day_counter: an integer calendar model with an input delay line
// is compared against the DUT on every falling edge, plus literal checks from the calendar rules.
module tb_day_counter;
  localparam int YEAR_W = 14;
  localparam int SYNC   = 1;

  logic              clk;
  logic              rstn;
  logic              tick_in;
  logic              set_enable;
  logic              set_mode;
  logic              inc;
  logic              dec;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic [4:0]        day;
  logic [3:0]        day_tens;
  logic [3:0]        day_units;
  logic              day_done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  day_counter #(.YEAR_W(YEAR_W), .SYNC_INPUTS(SYNC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tick_in   (tick_in),
    .set_enable(set_enable),
    .set_mode  (set_mode),
    .inc       (inc),
    .dec       (dec),
    .month     (month),
    .year      (year),
    .day       (day),
    .day_tens  (day_tens),
    .day_units (day_units),
    .day_done  (day_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dim_of(input int mo, input int yr);
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    if (mo == 2) begin
`ifdef LEAP_YEAR_EN
      if (((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0)) return 29;
`endif
      return (yr < 0) ? 0 : 28;
    end
    return 31;
  endfunction

  // Calendar model; hist_* keep the last input levels (index 0 = previous edge).
  int       m_day;
  bit       m_done;
  bit [3:0] hist_i, hist_d, cur_i, cur_d;
  bit       s_i, q_i, s_d, q_d, r_i, r_d;
  int       m_dim;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_day  = 1;
      m_done = 1'b0;
      hist_i = '0;
      hist_d = '0;
    end else begin
      cur_i = {hist_i[2:0], inc};
      cur_d = {hist_d[2:0], dec};
      s_i = (SYNC != 0) ? cur_i[2] : cur_i[0];
      q_i = (SYNC != 0) ? cur_i[3] : cur_i[1];
      s_d = (SYNC != 0) ? cur_d[2] : cur_d[0];
      q_d = (SYNC != 0) ? cur_d[3] : cur_d[1];
      r_i = s_i && !q_i;
      r_d = s_d && !q_d;
      m_dim  = dim_of(int'(month), int'(year));
      m_done = 1'b0;
      if (set_enable && set_mode && (r_i != r_d)) begin
        if (r_i) m_day = (m_day >= m_dim) ? 1 : m_day + 1;
        else     m_day = (m_day <= 1) ? m_dim : m_day - 1;
      end else if (!set_enable && tick_in) begin
        if (m_day >= m_dim) begin
          m_day  = 1;
          m_done = 1'b1;
        end else begin
          m_day = m_day + 1;
        end
      end else if (m_day > m_dim) begin
        m_day = m_dim;
      end
      hist_i = cur_i;
      hist_d = cur_d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("day", int'(day), m_day);
      check("day_tens", int'(day_tens), m_day / 10);
      check("day_units", int'(day_units), m_day % 10);
      check("day_done", int'(day_done), int'(m_done));
    end
  end

  task automatic tick_once();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
  endtask

  task automatic pulse(input bit pi, input bit pd);
    @(negedge clk);
    inc = pi;
    dec = pd;
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Leaves the bench in set mode with the model at target (bounded number of steps).
  task automatic set_day(input int target);
    @(negedge clk);
    set_enable = 1'b1;
    set_mode   = 1'b1;
    for (int g = 0; g < 40 && m_day != target; g++) pulse(1'b1, 1'b0);
    check("set_day", int'(day), target);
  endtask

  initial begin
    rstn = 1'b1; tick_in = 1'b0; set_enable = 1'b0; set_mode = 1'b0;
    inc = 1'b0; dec = 1'b0; month = 4'd1; year = 14'd2024;
    #3 rstn = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_day", int'(day), 1);
    check("rst_units", int'(day_units), 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset mid-count takes effect without a clock edge.
    repeat (14) tick_once();
    check("pre_rst_day", int'(day), 15);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_day", int'(day), 1);
    check("async_rst_tens", int'(day_tens), 0);
    check("async_rst_units", int'(day_units), 1);
    check("async_rst_done", int'(day_done), 0);
    @(negedge clk) rstn = 1'b1;

    // January rollover.
    repeat (30) tick_once();
    check("jan_day31", int'(day), 31);
    check("jan_tens", int'(day_tens), 3);
    check("jan_done0", int'(day_done), 0);
    tick_once();
    check("jan_wrap_day", int'(day), 1);
    check("jan_wrap_done", int'(day_done), 1);
    @(negedge clk);
    check("jan_done_pulse", int'(day_done), 0);

    // February, leap handling.
    month = 4'd2;
    year  = 14'd2024;
    set_day(28);
    set_enable = 1'b0; set_mode = 1'b0;
    tick_once();
`ifdef LEAP_YEAR_EN
    check("feb2024_29", int'(day), 29);
    tick_once();
    check("feb2024_wrap", int'(day), 1);
    check("feb2024_done", int'(day_done), 1);
    year = 14'd1900;
    set_day(28);
    set_enable = 1'b0; set_mode = 1'b0;
    tick_once();
    check("feb1900_wrap", int'(day), 1);
    check("feb1900_done", int'(day_done), 1);
    year = 14'd2000;
    set_day(28);
    set_enable = 1'b0; set_mode = 1'b0;
    tick_once();
    check("feb2000_29", int'(day), 29);
`else
    check("feb_noleap_wrap", int'(day), 1);
    check("feb_noleap_done", int'(day_done), 1);
`endif

    // Set mode stepping.
    month = 4'd1;
    set_day(1);
    pulse(1'b0, 1'b1);
    check("set_dec_wrap", int'(day), 31);
    check("set_done0", int'(day_done), 0);
    pulse(1'b1, 1'b0);
    check("set_inc_wrap", int'(day), 1);
    @(negedge clk) inc = 1'b1;
    repeat (10) @(negedge clk);
    inc = 1'b0;
    repeat (3) @(negedge clk);
    check("set_inc_held", int'(day), 2);
    pulse(1'b1, 1'b1);
    check("set_both", int'(day), 2);
    repeat (3) tick_once();
    check("set_tick_ignored", int'(day), 2);
    set_mode = 1'b0;
    pulse(1'b1, 1'b0);
    check("set_hold", int'(day), 2);
    set_mode = 1'b1;
    repeat (4) @(negedge clk);
    check("set_consumed", int'(day), 2);

    // Clamp on month/year change.
    set_day(31);
    set_enable = 1'b0; set_mode = 1'b0;
    @(negedge clk) month = 4'd4;
    @(negedge clk);
    check("clamp_apr", int'(day), 30);
    month = 4'd2;
    year  = 14'd2023;
    @(negedge clk);
    check("clamp_feb", int'(day), 28);
    check("clamp_done0", int'(day_done), 0);

    // Illegal month behaves as 31 days.
    month = 4'd13;
    set_day(30);
    set_enable = 1'b0; set_mode = 1'b0;
    tick_once();
    check("m13_31", int'(day), 31);
    tick_once();
    check("m13_wrap", int'(day), 1);
    check("m13_done", int'(day_done), 1);

    // Random phase.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      tick_in = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) set_enable = ~set_enable;
      if ($urandom_range(0, 15) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 3) == 0) inc = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) dec = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 23) == 0) month = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 4))
          0: year = 14'd2024;
          1: year = 14'd1900;
          2: year = 14'd2000;
          3: year = 14'd2023;
          default: year = 14'($urandom_range(0, 9999));
        endcase
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
